bus_select_decoder: RTL and testbench



---
 rtl/bus_sel_pkg.sv | 39 +++
 rtl/bus_select_decoder_onehot_dec.sv | 19 +
 rtl/bus_select_decoder.sv | 122 ++++++++++++
 tb/tb_bus_select_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_sel_pkg.sv
// Shared definitions for the bus source select encoder/decoder pair:
// code width, source count, named source codes and the decoder state enum.
package bus_sel_pkg;

    localparam int SEL_W   = 5;
    localparam int NUM_SRC = 24;

    localparam logic [SEL_W-1:0] SEL_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SEL_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SEL_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SEL_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SEL_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SEL_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SEL_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SEL_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SEL_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SEL_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SEL_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SEL_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SEL_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SEL_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SEL_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SEL_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SEL_PC     = 5'd18;
    localparam logic [SEL_W-1:0] SEL_MDR    = 5'd19;
    localparam logic [SEL_W-1:0] SEL_INPORT = 5'd20;
    localparam logic [SEL_W-1:0] SEL_ZHIGH  = 5'd21;
    localparam logic [SEL_W-1:0] SEL_ZLOW   = 5'd22;
    localparam logic [SEL_W-1:0] SEL_C      = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_sel_state_e;

endpackage

// File: rtl/bus_select_decoder_onehot_dec.sv
// Combinational code-to-one-hot decoder; codes at or above NUM_SRC decode to zero.
import bus_sel_pkg::*;

module onehot_dec #(
    parameter int NUM_SRC = bus_sel_pkg::NUM_SRC,
    parameter int SEL_W   = bus_sel_pkg::SEL_W
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            onehot[i] = (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/bus_select_decoder.sv
// Turns accepted bus source codes into registered one-hot drive enables,
// with all-off turnaround cycles between different drivers and bad-code tracking.
//
// Handshake: a request transfers on a rising edge where sel_valid and sel_ready
// are both high; sel_ready depends only on state and is low exactly in TURN.
import bus_sel_pkg::*;

module bus_select_decoder #(
    parameter int NUM_SRC     = bus_sel_pkg::NUM_SRC,
    parameter int SEL_W       = bus_sel_pkg::SEL_W,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel,
    output logic                 sel_ready,
    input  logic                 release_req,
    output logic [NUM_SRC-1:0]   drive_en,
    output logic                 bus_idle,
    output logic                 bad_sel,
    output logic [7:0]           bad_count,
    output bus_sel_state_e       dbg_state
);

    localparam int TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TC_W-1:0] TC_LOAD = TC_W'(TURN_CYCLES - 1);

    bus_sel_state_e      state;
    logic [SEL_W-1:0]    cur;
    logic [SEL_W-1:0]    pend;
    logic [NUM_SRC-1:0]  pend_oh;
    logic [TC_W-1:0]     tcnt;
    logic                cancel;

    logic [NUM_SRC-1:0]  sel_oh;
    logic                accept;
    logic                legal;

    onehot_dec #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_dec (
        .sel    (sel),
        .onehot (sel_oh)
    );

    assign sel_ready = (state != ST_TURN);
    assign accept    = sel_valid & sel_ready;
    assign legal     = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ST_IDLE;
            cur       <= '0;
            pend      <= '0;
            pend_oh   <= '0;
            tcnt      <= '0;
            cancel    <= 1'b0;
            drive_en  <= '0;
            bus_idle  <= 1'b1;
            bad_sel   <= 1'b0;
            bad_count <= '0;
        end else begin
            if (accept && !legal) begin
                bad_sel <= 1'b1;
                if (bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept && legal) begin
                        cur      <= sel;
                        drive_en <= sel_oh;
                        bus_idle <= 1'b0;
                        state    <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Any accept, even an illegal one, overrides release.
                    if (accept) begin
                        if (legal && (sel != cur)) begin
                            pend     <= sel;
                            pend_oh  <= sel_oh;
                            tcnt     <= TC_LOAD;
                            cancel   <= 1'b0;
                            drive_en <= '0;
                            bus_idle <= 1'b1;
                            state    <= ST_TURN;
                        end
                    end else if (release_req) begin
                        drive_en <= '0;
                        bus_idle <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_TURN: begin
                    if (tcnt == '0) begin
                        if (cancel || release_req) begin
                            state <= ST_IDLE;
                        end else begin
                            cur      <= pend;
                            drive_en <= pend_oh;
                            bus_idle <= 1'b0;
                            state    <= ST_DRIVE;
                        end
                    end else begin
                        tcnt <= tcnt - 1'b1;
                        if (release_req) cancel <= 1'b1;
                    end
                end
                default: begin
                    drive_en <= '0;
                    bus_idle <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_select_decoder.sv
// Directed bench for bus_select_decoder plus a random accept/release stream
// checked for one-hot enables and break-before-make between drivers.
import bus_sel_pkg::*;

module tb_bus_select_decoder;

    localparam int NS = bus_sel_pkg::NUM_SRC;
    localparam int SW = bus_sel_pkg::SEL_W;

    logic           clock = 1'b0;
    logic           clear = 1'b0;
    logic           sel_valid = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic           sel_ready;
    logic           release_req = 1'b0;
    logic [NS-1:0]  drive_en;
    logic           bus_idle;
    logic           bad_sel;
    logic [7:0]     bad_count;
    bus_sel_state_e dbg_state;

    int check_cnt = 0;
    int error_cnt = 0;

    bus_select_decoder #(
        .NUM_SRC     (NS),
        .SEL_W       (SW),
        .TURN_CYCLES (1)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .sel_ready   (sel_ready),
        .release_req (release_req),
        .drive_en    (drive_en),
        .bus_idle    (bus_idle),
        .bad_sel     (bad_sel),
        .bad_count   (bad_count),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) else begin
            error_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drive"}, 32'(drive_en), 32'h0);
        chk({tag, "_idle"}, 32'(bus_idle), 32'h1);
        chk({tag, "_ready"}, 32'(sel_ready), 32'h1);
        chk({tag, "_bad"}, 32'(bad_sel), 32'h0);
        chk({tag, "_cnt"}, 32'(bad_count), 32'h0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    logic [NS-1:0] last_nz;
    int            zero_run;

    initial begin
        // Reset
        clear = 1'b1;
        cyc();
        cyc();
        clear = 1'b0;
        chk_reset_vals("reset");

        // IDLE accept of PC, then release
        sel_valid = 1'b1; sel = SEL_PC;
        cyc();
        sel_valid = 1'b0;
        chk("pc_drive", 32'(drive_en), 32'h0004_0000);
        chk("pc_idle", 32'(bus_idle), 32'h0);
        release_req = 1'b1;
        cyc();
        release_req = 1'b0;
        chk("rel_drive", 32'(drive_en), 32'h0);
        chk("rel_idle", 32'(bus_idle), 32'h1);

        // Same code re-accepted, then a different one
        sel_valid = 1'b1; sel = SEL_R3;
        cyc();
        chk("r3_drive", 32'(drive_en), 32'h0000_0008);
        cyc();
        chk("r3_again", 32'(drive_en), 32'h0000_0008);
        chk("r3_again_st", 32'(dbg_state), 32'(ST_DRIVE));
        sel = SEL_ZLOW;
        cyc();
        sel_valid = 1'b0;
        chk("turn_drive", 32'(drive_en), 32'h0);
        chk("turn_ready", 32'(sel_ready), 32'h0);
        chk("turn_idle", 32'(bus_idle), 32'h1);
        cyc();
        chk("zlow_drive", 32'(drive_en), 32'h0040_0000);
        chk("zlow_ready", 32'(sel_ready), 32'h1);
        release_req = 1'b1;
        cyc();
        release_req = 1'b0;
        chk("zlow_rel", 32'(drive_en), 32'h0);

        // Illegal codes in IDLE, then saturation
        sel_valid = 1'b1;
        sel = 5'd27; cyc();
        sel = 5'd31; cyc();
        sel = 5'd24; cyc();
        sel_valid = 1'b0;
        chk("bad_flag", 32'(bad_sel), 32'h1);
        chk("bad_cnt3", 32'(bad_count), 32'd3);
        chk("bad_drive", 32'(drive_en), 32'h0);
        sel_valid = 1'b1; sel = 5'd25;
        for (int i = 0; i < 252; i++) cyc();
        chk("bad_cnt255", 32'(bad_count), 32'd255);
        for (int i = 0; i < 4; i++) cyc();
        sel_valid = 1'b0;
        chk("bad_sat", 32'(bad_count), 32'd255);
        chk("bad_sat_drive", 32'(drive_en), 32'h0);

        // sel_valid wins over release; release during TURN cancels
        sel_valid = 1'b1; sel = SEL_R5;
        cyc();
        chk("r5_drive", 32'(drive_en), 32'h0000_0020);
        sel = SEL_R9; release_req = 1'b1;
        cyc();
        sel_valid = 1'b0; release_req = 1'b0;
        chk("prio_turn", 32'(drive_en), 32'h0);
        chk("prio_state", 32'(dbg_state), 32'(ST_TURN));
        cyc();
        chk("r9_drive", 32'(drive_en), 32'h0000_0200);
        sel_valid = 1'b1; sel = SEL_R5;
        cyc();
        sel_valid = 1'b0; release_req = 1'b1;
        chk("cancel_turn", 32'(dbg_state), 32'(ST_TURN));
        cyc();
        release_req = 1'b0;
        chk("cancel_drive", 32'(drive_en), 32'h0);
        chk("cancel_state", 32'(dbg_state), 32'(ST_IDLE));
        cyc();
        chk("cancel_stay", 32'(drive_en), 32'h0);

        // clear during TURN with HI pending
        sel_valid = 1'b1; sel = SEL_R1;
        cyc();
        sel = SEL_HI;
        cyc();
        sel_valid = 1'b0;
        chk("clr_pre", 32'(dbg_state), 32'(ST_TURN));
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk_reset_vals("clr");
        cyc();
        chk("clr_no_hi", 32'(drive_en), 32'h0);

        // Random accept/release stream
        last_nz  = '0;
        zero_run = 0;
        for (int i = 0; i < 600; i++) begin
            sel_valid   = ($urandom_range(0, 99) < 60);
            sel         = SW'($urandom_range(0, 26));
            release_req = ($urandom_range(0, 99) < 25);
            cyc();
            chk("rnd_onehot", 32'($onehot0(drive_en)), 32'h1);
            chk("rnd_idle", 32'(bus_idle), 32'(drive_en == '0));
            if (drive_en == '0) begin
                zero_run++;
            end else begin
                if (last_nz != '0 && drive_en != last_nz)
                    chk("rnd_gap", 32'(zero_run >= 1), 32'h1);
                last_nz  = drive_en;
                zero_run = 0;
            end
        end
        sel_valid = 1'b0;
        release_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
